// File: rtl/pong_frame_renderer.sv
// pong_frame_renderer: 640x480@60 raster timing plus ball/paddle/net pixels from per-frame latched positions
// Ports: clk pixel clock; reset sync active-high; bal_x/bal_y ball top-left;
//        pongbar1_y/pongbar2_y paddle tops; vid_hs/vid_vs active-low syncs;
//        vid_de active-area enable; vid_r/g/b pixel colour; frame_start latch pulse.
module pong_frame_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BALL_SIZE = 8,
  parameter int BAR_W     = 8,
  parameter int BAR_H     = 64,
  parameter int BAR1_X    = 16,
  parameter int BAR2_X    = 616,
  parameter int NET_X     = 318
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bal_x,
  input  logic [15:0] bal_y,
  input  logic [15:0] pongbar1_y,
  input  logic [15:0] pongbar2_y,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [15:0] sh_bx, sh_by, sh_b1, sh_b2;
  logic [16:0] x, y;
  logic h_last, v_last, latch, de0, hs0, vs0, ball0, bar10, bar20, net0;
  logic de1, hs1, vs1, ball1, bar11, bar21, net1;
  logic [23:0] rgb;
  // Span test at 17 bits so an object near 0xFFFF clips instead of wrapping onto x/y 0.
  function automatic logic span(input logic [16:0] p, input logic [15:0] lo, input int len);
    return p >= {1'b0, lo} && p < {1'b0, lo} + 17'(len);
  endfunction
  always_comb begin
    x = 17'(h_cnt);
    y = 17'(v_cnt);
    h_last = h_cnt == HW'(H_TOTAL - 1);
    v_last = v_cnt == VW'(V_TOTAL - 1);
    latch = h_cnt == '0 && v_cnt == VW'(V_ACTIVE);
    de0 = x < 17'(H_ACTIVE) && y < 17'(V_ACTIVE);
    hs0 = !span(x, 16'(H_ACTIVE + H_FP), H_SYNC);
    vs0 = !span(y, 16'(V_ACTIVE + V_FP), V_SYNC);
    ball0 = span(x, sh_bx, BALL_SIZE) && span(y, sh_by, BALL_SIZE);
    bar10 = span(x, 16'(BAR1_X), BAR_W) && span(y, sh_b1, BAR_H);
    bar20 = span(x, 16'(BAR2_X), BAR_W) && span(y, sh_b2, BAR_H);
    net0 = span(x, 16'(NET_X), 4) && !y[4];
    rgb = !de1 ? 24'h000000 : (ball1 || bar11 || bar21) ? 24'hFFFFFF : net1 ? 24'h808080 : 24'h000000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      {sh_bx, sh_by, sh_b1, sh_b2} <= '0;
      {de1, ball1, bar11, bar21, net1} <= '0;
      {hs1, vs1} <= 2'b11;
      {vid_de, frame_start} <= 2'b00;
      {vid_hs, vid_vs} <= 2'b11;
      {vid_r, vid_g, vid_b} <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      if (latch) {sh_bx, sh_by, sh_b1, sh_b2} <= {bal_x, bal_y, pongbar1_y, pongbar2_y};
      frame_start <= latch;
      {de1, hs1, vs1, ball1, bar11, bar21, net1} <= {de0, hs0, vs0, ball0, bar10, bar20, net0};
      {vid_de, vid_hs, vid_vs} <= {de1, hs1, vs1};
      {vid_r, vid_g, vid_b} <= rgb;
    end
  end
endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb_pong_frame_renderer: scoreboard plus pixel-vector bench for pong_frame_renderer on a shrunken raster
module tb_pong_frame_renderer;
  localparam int HA = 64, HF = 2, HS = 4, HB = 2;
  localparam int VA = 48, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BS = 4, BW = 2, BH = 8, B1X = 2, B2X = 60, NX = 30;
  localparam logic [23:0] W = 24'hFFFFFF, G = 24'h808080, K = 24'h000000;
  logic clk = 0, reset = 1;
  logic [15:0] bal_x = 10, bal_y = 20, pongbar1_y = 0, pongbar2_y = 44;
  logic vid_hs, vid_vs, vid_de, frame_start;
  logic [7:0] vid_r, vid_g, vid_b;
  always #5 clk = ~clk;
  pong_frame_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_SIZE(BS), .BAR_W(BW), .BAR_H(BH), .BAR1_X(B1X), .BAR2_X(B2X), .NET_X(NX)
  ) dut (
    .clk(clk), .reset(reset), .bal_x(bal_x), .bal_y(bal_y),
    .pongbar1_y(pongbar1_y), .pongbar2_y(pongbar2_y),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .frame_start(frame_start)
  );
  typedef struct {logic [26:0] v; int x; int y;} exp_t;
  typedef struct {logic [15:0] bx, by, b1, b2; int px, py; logic [23:0] rgb;} vec_t;
  exp_t q[$];
  vec_t vt[$];
  int mx, my, n_chk = 0, n_fail = 0;
  logic [15:0] sx, sy, s1, s2;
  logic fs_pend;
  logic [23:0] fb [VA][HA];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic in_span(int p, int lo, int len);
    return p >= lo && p < lo + len;
  endfunction
  function automatic logic [26:0] expect_px(int px, int py);
    logic de, hs, vs, hit;
    logic [23:0] c;
    de = px < HA && py < VA;
    hs = !in_span(px, HA + HF, HS);
    vs = !in_span(py, VA + VF, VS);
    hit = (in_span(px, int'(sx), BS) && in_span(py, int'(sy), BS)) ||
          (in_span(px, B1X, BW) && in_span(py, int'(s1), BH)) ||
          (in_span(px, B2X, BW) && in_span(py, int'(s2), BH));
    c = !de ? K : hit ? W : (in_span(px, NX, 4) && (py % 32) < 16) ? G : K;
    return {hs, vs, de, c};
  endfunction
  // Reference raster: predicts every output cycle two clocks ahead, flushed by reset.
  initial forever begin
    @(negedge clk);
    if (q.size() == 2) begin
      check($sformatf("pixel(%0d,%0d)", q[0].x, q[0].y),
            {vid_hs, vid_vs, vid_de, frame_start, vid_r, vid_g, vid_b},
            {q[0].v[26:24], fs_pend, q[0].v[23:0]});
      if (q[0].v[24]) fb[q[0].y][q[0].x] = {vid_r, vid_g, vid_b};
      void'(q.pop_front());
    end
    if (reset) begin
      q.delete();
      q.push_back('{{1'b1, 1'b1, 1'b0, 24'h0}, -1, -1});
      q.push_back('{{1'b1, 1'b1, 1'b0, 24'h0}, -1, -1});
      mx = 0; my = 0; sx = 0; sy = 0; s1 = 0; s2 = 0; fs_pend = 0;
    end else begin
      q.push_back('{expect_px(mx, my), mx, my});
      fs_pend = mx == 0 && my == VA;
      if (fs_pend) {sx, sy, s1, s2} = {bal_x, bal_y, pongbar1_y, pongbar2_y};
      mx = mx == HT - 1 ? 0 : mx + 1;
      if (mx == 0) my = my == VT - 1 ? 0 : my + 1;
    end
  end
  task automatic wait_fs();
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!frame_start && k < 2 * HT * VT);
    if (!frame_start) check("frame_start_timeout", frame_start, 1);
  endtask
  task automatic wait_xy(input int tx, input int ty);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!(mx == tx && my == ty) && k < 2 * HT * VT);
    if (!(mx == tx && my == ty)) check("xy_timeout", {mx[15:0], my[15:0]}, {tx[15:0], ty[15:0]});
  endtask
  task automatic first_de();
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!vid_de && k < 10);
    check("first_de_latency", k, 2);
  endtask
  task automatic add(input logic [15:0] bx, by, b1, b2, input int px, py, input logic [23:0] rgb);
    vt.push_back('{bx, by, b1, b2, px, py, rgb});
  endtask
  initial begin
    int hs_lo, vs_lo, de_hi, fs_n;
    add(10, 20, 0, 44, 10, 20, W);  add(10, 20, 0, 44, 13, 23, W);  add(10, 20, 0, 44, 14, 20, K);
    add(10, 20, 0, 44, 9, 20, K);   add(10, 20, 0, 44, 10, 24, K);  add(10, 20, 0, 44, 2, 0, W);
    add(10, 20, 0, 44, 3, 7, W);    add(10, 20, 0, 44, 2, 8, K);    add(10, 20, 0, 44, 4, 0, K);
    add(10, 20, 0, 44, 60, 44, W);  add(10, 20, 0, 44, 61, 47, W);  add(10, 20, 0, 44, 59, 44, K);
    add(10, 20, 0, 44, 30, 0, G);   add(10, 20, 0, 44, 33, 15, G);  add(10, 20, 0, 44, 30, 16, K);
    add(10, 20, 0, 44, 34, 0, K);   add(10, 20, 0, 44, 31, 32, G);
    add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 0, 0, K);  add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 1, 1, K);
    add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 2, 0, K);  add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 2, 3, K);
    add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 60, 0, W); add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 61, 7, W);
    add(16'hFFFE, 16'hFFFE, 16'hFFFC, 0, 60, 8, K);
    add(30, 0, 20, 20, 30, 0, W);   add(30, 0, 20, 20, 33, 3, W);   add(30, 0, 20, 20, 31, 4, G);
    add(30, 0, 20, 20, 34, 0, K);   add(30, 0, 20, 20, 2, 20, W);   add(30, 0, 20, 20, 2, 28, K);
    add(30, 0, 20, 20, 2, 19, K);
    add(62, 40, 0, 0, 62, 40, W);   add(62, 40, 0, 0, 63, 43, W);   add(62, 40, 0, 0, 0, 41, K);
    repeat (10) @(posedge clk);
    #1;
    check("reset_outputs", {vid_hs, vid_vs, vid_de, frame_start, vid_r, vid_g, vid_b}, {4'b1100, 24'h0});
    reset = 0;
    first_de();
    wait_fs();
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0;
    for (int i = 1; i <= HT * VT; i++) begin
      @(posedge clk); #1;
      hs_lo += int'(!vid_hs); vs_lo += int'(!vid_vs); de_hi += int'(vid_de); fs_n += int'(frame_start);
    end
    check("hs_low_cycles", hs_lo, HS * VT);
    check("vs_low_cycles", vs_lo, VS * HT);
    check("de_cycles", de_hi, HA * VA);
    check("fs_count", fs_n, 1);
    check("fs_period", frame_start, 1);
    foreach (vt[i]) begin
      if ({vt[i].bx, vt[i].by, vt[i].b1, vt[i].b2} != {bal_x, bal_y, pongbar1_y, pongbar2_y}) begin
        {bal_x, bal_y, pongbar1_y, pongbar2_y} = {vt[i].bx, vt[i].by, vt[i].b1, vt[i].b2};
        wait_fs();
        wait_fs();
      end
      check($sformatf("vec%0d(%0d,%0d)", i, vt[i].px, vt[i].py), fb[vt[i].py][vt[i].px], vt[i].rgb);
    end
    wait_xy(0, 24);
    bal_x = 10;
    wait_fs();
    check("mid_old_pos", fb[40][62], W);
    check("mid_new_absent", fb[40][10], K);
    wait_fs();
    check("next_new_pos", fb[40][10], W);
    check("next_old_absent", fb[40][62], K);
    wait_xy(0, VA);
    bal_x = 50;
    @(posedge clk); #1;
    check("latch_fs", frame_start, 1);
    bal_x = 5;
    wait_fs();
    check("latch_value_taken", fb[40][50], W);
    check("latch_late_ignored", fb[40][5], K);
    wait_xy(0, 30);
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("midframe_reset_outputs", {vid_hs, vid_vs, vid_de, frame_start, vid_r, vid_g, vid_b}, {4'b1100, 24'h0});
    reset = 0;
    first_de();
    repeat (HT * 4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
